// File: rtl/time_counter.sv
// time_counter: BCD 24-hour time-of-day counter with prescaler, validated load and minute/hour adjust.
module time_counter #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [23:0] ld_time,
    input  logic        inc_min,
    input  logic        inc_hr,
    output logic [3:0]  ht,
    output logic [3:0]  ho,
    output logic [3:0]  mt,
    output logic [3:0]  mo,
    output logic [3:0]  st,
    output logic [3:0]  so,
    output logic        sec_pulse,
    output logic        day_wrap,
    output logic        load_err
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc, presc_nx;
    logic          tick, ld_ok, s_c, m_c, h_last;
    logic [3:0]    mo_a, mt_a, ho_a, ht_a;

    always_comb begin
        tick     = en && presc == LAST;
        presc_nx = en ? (tick ? '0 : presc + 1'b1) : presc;
        ld_ok    = ld_time[23:20] <= 4'd2 && ld_time[19:16] <= 4'd9 &&
                   (ld_time[23:20] != 4'd2 || ld_time[19:16] <= 4'd3) &&
                   ld_time[15:12] <= 4'd5 && ld_time[11:8] <= 4'd9 &&
                   ld_time[7:4] <= 4'd5 && ld_time[3:0] <= 4'd9;
        // one-step minute and hour advances, shared by tick carries and adjust pulses
        mo_a     = mo == 4'd9 ? 4'd0 : mo + 4'd1;
        mt_a     = mo == 4'd9 ? (mt == 4'd5 ? 4'd0 : mt + 4'd1) : mt;
        h_last   = ht == 4'd2 && ho == 4'd3;
        ho_a     = (h_last || ho == 4'd9) ? 4'd0 : ho + 4'd1;
        ht_a     = h_last ? 4'd0 : (ho == 4'd9 ? ht + 4'd1 : ht);
        s_c      = so == 4'd9 && st == 4'd5;
        m_c      = s_c && mo == 4'd9 && mt == 4'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            {ht, ho, mt, mo, st, so} <= '0;
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (ld_ok) begin
                    {ht, ho, mt, mo, st, so} <= ld_time;
                    presc <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                presc <= presc_nx;
                if (inc_hr) begin
                    {ht, ho} <= {ht_a, ho_a};
                end else if (inc_min) begin
                    {mt, mo} <= {mt_a, mo_a};
                end else if (tick) begin
                    so <= so == 4'd9 ? 4'd0 : so + 4'd1;
                    st <= so == 4'd9 ? (st == 4'd5 ? 4'd0 : st + 4'd1) : st;
                    if (s_c) {mt, mo} <= {mt_a, mo_a};
                    if (m_c) {ht, ho} <= {ht_a, ho_a};
                    sec_pulse <= 1'b1;
                    day_wrap  <= m_c && h_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: random and directed stimulus against a seconds-of-day reference model.
module tb_time_counter;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, load = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
    logic [23:0] ld_time = '0;
    logic [3:0]  ht, ho, mt, mo, st, so;
    logic        sec_pulse, day_wrap, load_err;

    int checks = 0, errors = 0;
    int m_t = 0, m_p = 0;
    bit m_sp = 0, m_dw = 0, m_le = 0;
    int pulses;

    time_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .ld_time(ld_time),
        .inc_min(inc_min), .inc_hr(inc_hr),
        .ht(ht), .ho(ho), .mt(mt), .mo(mo), .st(st), .so(so),
        .sec_pulse(sec_pulse), .day_wrap(day_wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit legal(input logic [23:0] v);
        int h;
        h = 10 * int'(v[23:20]) + int'(v[19:16]);
        return v[19:16] <= 9 && v[11:8] <= 9 && v[3:0] <= 9 && h < 24 &&
               v[15:12] <= 5 && v[7:4] <= 5;
    endfunction

    function automatic int to_sec(input logic [23:0] v);
        return 36000 * int'(v[23:20]) + 3600 * int'(v[19:16]) + 600 * int'(v[15:12]) +
               60 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    task automatic model();
        bit tk;
        m_sp = 0; m_dw = 0; m_le = 0;
        if (rst) begin
            m_t = 0; m_p = 0;
        end else if (load) begin
            if (legal(ld_time)) begin
                m_t = to_sec(ld_time); m_p = 0;
            end else m_le = 1;
        end else begin
            tk = en && m_p == TD - 1;
            if (en) m_p = (m_p + 1) % TD;
            if (inc_hr) m_t = ((m_t / 3600 + 1) % 24) * 3600 + m_t % 3600;
            else if (inc_min) m_t = (m_t / 3600) * 3600 + ((m_t / 60 % 60 + 1) % 60) * 60 + m_t % 60;
            else if (tk) begin
                m_t = (m_t + 1) % 86400;
                m_sp = 1;
                m_dw = m_t == 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input logic [23:0] ld,
                       input bit im, input bit ih);
        rst = r; en = e; load = l; ld_time = ld; inc_min = im; inc_hr = ih;
        @(posedge clk);
        model();
        #1;
        chk("time", 32'({ht, ho, mt, mo, st, so}), 32'(to_bcd(m_t)));
        chk("sec_pulse", 32'(sec_pulse), 32'(m_sp));
        chk("day_wrap", 32'(day_wrap), 32'(m_dw));
        chk("load_err", 32'(load_err), 32'(m_le));
        if (sec_pulse) pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 24'h0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 24'h0, 0, 0);
        cyc(1, 1, 0, 24'h0, 0, 0);
        pulses = 0;
        run(40);
        chk("pulses_40", 32'(pulses), 32'd10);
        chk("time_40", 32'({ht, ho, mt, mo, st, so}), 32'h000010);

        cyc(0, 1, 1, 24'h235958, 0, 0);
        run(8);
        cyc(0, 1, 1, 24'h245900, 0, 0);
        cyc(0, 1, 1, 24'h126000, 0, 0);
        cyc(0, 0, 1, 24'h195959, 0, 0);
        run(4);
        chk("after_195959", 32'({ht, ho, mt, mo, st, so}), 32'h200000);

        cyc(0, 0, 1, 24'h105930, 0, 0);
        cyc(0, 1, 0, 24'h0, 1, 0);
        chk("inc_min_wrap", 32'({ht, ho, mt, mo, st, so}), 32'h100030);
        cyc(0, 0, 1, 24'h231234, 0, 0);
        cyc(0, 0, 0, 24'h0, 0, 1);
        chk("inc_hr_wrap", 32'({ht, ho, mt, mo, st, so}), 32'h001234);

        cyc(0, 1, 1, 24'h000000, 0, 0);
        run(3);
        cyc(0, 1, 1, 24'h120000, 0, 0);
        chk("load_vs_tick", 32'({sec_pulse, ht, ho, mt, mo, st, so}), 32'h0120000);
        run(4);

        cyc(0, 0, 1, 24'h050607, 0, 0);
        run(2);
        cyc(1, 1, 0, 24'h0, 0, 0);
        pulses = 0;
        run(3);
        chk("no_early_tick", 32'(pulses), 32'd0);
        run(1);
        chk("tick_after_rst", 32'(sec_pulse), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            logic [23:0] v;
            int k;
            k = $urandom_range(0, 99);
            v = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 86399)) : 24'($urandom);
            if (k < 2) cyc(0, 1, 1, 24'h235955, 0, 0);
            else cyc(k < 3, $urandom_range(0, 9) != 0, k >= 3 && k < 7, v,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
